frame_burst_reader: RTL
=======================

# frame_burst_reader

Parametrised successor to the SDRAM frame-read controller: on a frame request it streams a frame from one of NUM_BUF frame buffers into the display-side FIFO as back-to-back burst reads on the App_rd interface. Adds a configurable read latency, a short final burst for lengths that are not burst multiples, and optional per-line horizontal mirroring. Sits between the video timing/read-request logic and the SDRAM controller user port, in the mem_clk domain.

## Interface
- ADDR_BITS, 21, word address width
- BURST_BITS, 9, burst length counter width
- BURST_SIZE, 128, nominal words per burst (≤ 2^BURST_BITS−1)
- FIFO_DEPTH, 512, FIFO capacity in words
- USEDW_BITS, 10, wrusedw width
- NUM_BUF, 4, number of frame base addresses (power of 2, ≥2)
- RD_LATENCY, 10, cycles from last app_rd_en to last data written into the FIFO
- LINE_WIDTH, 640, words per image line (mirror addressing)
- mem_clk in 1: clock
- rst in 1: asynchronous, active-high reset
- sdr_init_done in 1: SDRAM ready
- app_wr_busy in 1: write port owns the SDRAM; blocks new bursts
- app_rd_en out 1: one read command per high cycle
- app_rd_addr out ADDR_BITS: word address of the current command
- rd_busy out 1: high in ISSUE and DRAIN
- read_req in 1: async level request, held until read_req_ack
- read_req_ack out 1: request acknowledge
- read_finish out 1: one-cycle pulse, frame done
- read_addr in NUM_BUF*ADDR_BITS: packed base addresses, slot i at [i*ADDR_BITS +: ADDR_BITS]
- read_addr_index in $clog2(NUM_BUF): base address select
- read_len in ADDR_BITS: frame length in words
- mirror in 1: horizontal flip request (used only with FRAME_RD_MIRROR_EN)
- fifo_aclr out 1: FIFO clear, high during ACK
- wrusedw in USEDW_BITS: FIFO write-side fill level

## Operation
- Sync: read_req through 3 flops (req_s); read_addr_index, read_len, mirror through 2 flops.
- States: IDLE, ACK, CHECK, ISSUE, DRAIN, BURST_END, END.
- IDLE: req_s && sdr_init_done → ACK.
- ACK: while req_s, read_req_ack=1 and fifo_aclr=1; latch len, base=read_addr[index], mirror; cnt=0, col=0. When req_s falls → CHECK, ack and aclr drop to 0.
- CHECK: req_s → ACK (restart). Otherwise wrusedw < FIFO_DEPTH−BURST_SIZE && !app_wr_busy → ISSUE, with blen = min(BURST_SIZE, len−cnt).
- ISSUE: app_rd_en high for exactly blen consecutive cycles; address advances one word per command. After the last command → DRAIN.
- DRAIN: wait RD_LATENCY cycles → BURST_END; cnt += blen.
- BURST_END: req_s → ACK; else cnt < len → CHECK; else → END.
- END: read_finish=1 for one cycle → IDLE.
- A request arriving in ISSUE or DRAIN is not serviced until BURST_END. Bursts are never cut short.
- Linear addressing: addr = base + cnt + offset. Mirrored addressing: line_start + (LINE_WIDTH−1−col); when col wraps from LINE_WIDTH−1 to 0, line_start += LINE_WIDTH. Bursts may cross line boundaries.
- len = 0: CHECK goes directly to BURST_END, then END, with no app_rd_en.
- Address arithmetic is modulo 2^ADDR_BITS.

## Timing
- Reset values: app_rd_en=0, app_rd_addr=0, rd_busy=0, read_req_ack=0, read_finish=0, fifo_aclr=0, state=IDLE. Reset is honoured mid-burst; no command is emitted after rst rises.
- app_rd_en and app_rd_addr are registered. The first command appears in the first ISSUE cycle; app_rd_addr is valid in the same cycle as app_rd_en.
- Gap between consecutive bursts is at least RD_LATENCY+3 cycles.
- read_req to read_req_ack latency: 4 cycles (3 sync + 1).

## Configuration
- FRAME_RD_MIRROR_EN defined: the mirror input is sampled in ACK and mirrored addressing is compiled in.
- FRAME_RD_MIRROR_EN undefined: the mirror input is ignored, the line/column logic is removed, and addressing is linear only.

## Structure
- Shared package frame_rd_pkg: state enum, ONE/ZERO constants, min() function.
- One sub-module, frame_rd_addr_gen: address generation (linear/mirror, col and line_start counters), with load and step inputs.

## Test plan
- BURST_SIZE=128, len=512, index=2, empty FIFO → 4 bursts of 128 from read_addr[2], contiguous addresses, one read_finish pulse.
- len=300 → bursts of 128, 128, 44; exactly 300 app_rd_en cycles in total.
- wrusedw=400 (≥384) held → stays in CHECK, no app_rd_en; dropping wrusedw to 383 → ISSUE next cycle. app_wr_busy=1 also holds CHECK.
- New read_req raised in the middle of ISSUE → current burst completes (128 commands), then ACK with fifo_aclr=1, address reloaded.
- FRAME_RD_MIRROR_EN, LINE_WIDTH=640, base=0, mirror=1 → addresses 639…0, then 1279…640, with the line crossing handled inside a burst.
- rst pulse during DRAIN → all outputs return to reset values immediately; a fresh request completes normally.

Source files
------------

// File: rtl/frame_rd_pkg.sv
// frame_rd_pkg: shared types and helpers for the frame burst reader.
package frame_rd_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACK       = 3'd1,
      CHECK     = 3'd2,
      ISSUE     = 3'd3,
      DRAIN     = 3'd4,
      BURST_END = 3'd5,
      END       = 3'd6
   } rd_state_e;

   localparam logic ONE  = 1'b1;
   localparam logic ZERO = 1'b0;

   // Smaller of two unsigned values; used to size the final short burst.
   function automatic logic [31:0] min(input logic [31:0] a, input logic [31:0] b);
      if (a < b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/frame_rd_addr_gen.sv
// frame_rd_addr_gen: word address generator for one frame read.
// Linear addressing is base + running offset. When FRAME_RD_MIRROR_EN is
// defined, a mirrored mode walks each line from its last word to its first,
// moving to the next line after LINE_WIDTH words.
module frame_rd_addr_gen
   import frame_rd_pkg::*;
#(
   parameter int ADDR_BITS  = 21,
   parameter int LINE_WIDTH = 640
)(
   input  logic                 mem_clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [ADDR_BITS-1:0] base,
   input  logic                 mirror,
   output logic [ADDR_BITS-1:0] addr
);

   logic [ADDR_BITS-1:0] base_r;
   logic [ADDR_BITS-1:0] off_r;

`ifdef FRAME_RD_MIRROR_EN
   localparam int COL_BITS = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(LINE_WIDTH - 1);

   logic                 mirror_r;
   logic [COL_BITS-1:0]  col_r;
   logic [ADDR_BITS-1:0] line_start_r;

   // Frame origin, linear offset and mirrored line/column position.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         base_r       <= {ADDR_BITS{1'b0}};
         off_r        <= {ADDR_BITS{1'b0}};
         mirror_r     <= ZERO;
         col_r        <= {COL_BITS{1'b0}};
         line_start_r <= {ADDR_BITS{1'b0}};
      end else if (load) begin
         base_r       <= base;
         off_r        <= {ADDR_BITS{1'b0}};
         mirror_r     <= mirror;
         col_r        <= {COL_BITS{1'b0}};
         line_start_r <= base;
      end else if (step) begin
         off_r <= off_r + ADDR_BITS'(1);
         if (col_r == COL_LAST) begin
            col_r        <= {COL_BITS{1'b0}};
            line_start_r <= line_start_r + ADDR_BITS'(LINE_WIDTH);
         end else begin
            col_r <= col_r + COL_BITS'(1);
         end
      end
   end

   assign addr = mirror_r ? (line_start_r + ADDR_BITS'(LINE_WIDTH - 1) - ADDR_BITS'(col_r))
                          : (base_r + off_r);
`else
   // Mirroring is not built in this configuration; the input is ignored.
   logic unused_mirror_s;
   assign unused_mirror_s = mirror & (LINE_WIDTH > 0);

   // Frame origin and linear word offset.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         base_r <= {ADDR_BITS{1'b0}};
         off_r  <= {ADDR_BITS{1'b0}};
      end else if (load) begin
         base_r <= base;
         off_r  <= {ADDR_BITS{1'b0}};
      end else if (step) begin
         off_r <= off_r + ADDR_BITS'(1);
      end
   end

   assign addr = base_r + off_r;
`endif

endmodule

// File: rtl/frame_burst_reader.sv
// frame_burst_reader: streams one frame from a selected frame buffer into the
// display FIFO as back-to-back burst reads on the App_rd port, with a read
// latency drain after every burst and a short final burst.
// Build option FRAME_RD_MIRROR_EN adds per-line horizontal mirroring.
module frame_burst_reader
   import frame_rd_pkg::*;
#(
   parameter int ADDR_BITS  = 21,
   parameter int BURST_BITS = 9,
   parameter int BURST_SIZE = 128,
   parameter int FIFO_DEPTH = 512,
   parameter int USEDW_BITS = 10,
   parameter int NUM_BUF    = 4,
   parameter int RD_LATENCY = 10,
   parameter int LINE_WIDTH = 640
)(
   input  logic                         mem_clk,
   input  logic                         rst,
   input  logic                         sdr_init_done,
   input  logic                         app_wr_busy,
   output logic                         app_rd_en,
   output logic [ADDR_BITS-1:0]         app_rd_addr,
   output logic                         rd_busy,
   input  logic                         read_req,
   output logic                         read_req_ack,
   output logic                         read_finish,
   input  logic [NUM_BUF*ADDR_BITS-1:0] read_addr,
   input  logic [$clog2(NUM_BUF)-1:0]   read_addr_index,
   input  logic [ADDR_BITS-1:0]         read_len,
   input  logic                         mirror,
   output logic                         fifo_aclr,
   input  logic [USEDW_BITS-1:0]        wrusedw
);

   localparam int IDX_BITS = $clog2(NUM_BUF);
   localparam int DLY_BITS = $clog2(RD_LATENCY) + 1;
   localparam logic [USEDW_BITS-1:0] FILL_LIMIT = USEDW_BITS'(FIFO_DEPTH - BURST_SIZE);

   // Synchronisers for the request and its parameters.
   logic [2:0]           req_sync_r;
   logic                 req_s;
   logic [IDX_BITS-1:0]  idx_sync1_r, idx_sync2_r;
   logic [ADDR_BITS-1:0] len_sync1_r, len_sync2_r;
   logic                 mirror_sync1_r, mirror_sync2_r;

   rd_state_e            state_r, state_nxt;
   logic [ADDR_BITS-1:0] len_r;
   logic [ADDR_BITS-1:0] cnt_r;
   logic [BURST_BITS-1:0] blen_r;
   logic [BURST_BITS-1:0] bleft_r;
   logic [DLY_BITS-1:0]  dly_r;

   logic [ADDR_BITS-1:0] remain_s;
   logic [BURST_BITS-1:0] blen_s;
   logic [ADDR_BITS-1:0] base_s;
   logic [ADDR_BITS-1:0] gen_addr_s;
   logic                 fifo_ok_s;
   logic                 cmd_s;
   logic                 start_s;
   logic                 drain_done_s;
   logic                 load_s;

   // Bring the request level and frame parameters into mem_clk.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         req_sync_r     <= 3'b000;
         idx_sync1_r    <= {IDX_BITS{1'b0}};
         idx_sync2_r    <= {IDX_BITS{1'b0}};
         len_sync1_r    <= {ADDR_BITS{1'b0}};
         len_sync2_r    <= {ADDR_BITS{1'b0}};
         mirror_sync1_r <= ZERO;
         mirror_sync2_r <= ZERO;
      end else begin
         req_sync_r     <= {req_sync_r[1:0], read_req};
         idx_sync1_r    <= read_addr_index;
         idx_sync2_r    <= idx_sync1_r;
         len_sync1_r    <= read_len;
         len_sync2_r    <= len_sync1_r;
         mirror_sync1_r <= mirror;
         mirror_sync2_r <= mirror_sync1_r;
      end
   end

   assign req_s     = req_sync_r[2];
   assign base_s    = read_addr[idx_sync2_r*ADDR_BITS +: ADDR_BITS];
   assign remain_s  = len_r - cnt_r;
   assign blen_s    = BURST_BITS'(min(32'(BURST_SIZE), 32'(remain_s)));
   assign fifo_ok_s = (wrusedw < FILL_LIMIT);
   assign load_s    = (state_r == ACK);

   frame_rd_addr_gen #(
      .ADDR_BITS  (ADDR_BITS),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_addr_gen (
      .mem_clk (mem_clk),
      .rst     (rst),
      .load    (load_s),
      .step    (cmd_s),
      .base    (base_s),
      .mirror  (mirror_sync2_r),
      .addr    (gen_addr_s)
   );

   // FSM state register.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state logic; a command is issued whenever cmd_s is high.
   always_comb begin
      state_nxt    = state_r;
      cmd_s        = ZERO;
      start_s      = ZERO;
      drain_done_s = ZERO;
      case (state_r)
         IDLE: begin
            if (req_s && sdr_init_done) begin
               state_nxt = ACK;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACK: begin
            if (req_s) begin
               state_nxt = ACK;
            end else begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (req_s) begin
               state_nxt = ACK;
            end else if (remain_s == {ADDR_BITS{1'b0}}) begin
               state_nxt = BURST_END;
            end else if (fifo_ok_s && !app_wr_busy) begin
               state_nxt = ISSUE;
               cmd_s     = ONE;
               start_s   = ONE;
            end else begin
               state_nxt = CHECK;
            end
         end
         ISSUE: begin
            if (bleft_r != {BURST_BITS{1'b0}}) begin
               state_nxt = ISSUE;
               cmd_s     = ONE;
            end else begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (dly_r == {DLY_BITS{1'b0}}) begin
               state_nxt    = BURST_END;
               drain_done_s = ONE;
            end else begin
               state_nxt = DRAIN;
            end
         end
         BURST_END: begin
            if (req_s) begin
               state_nxt = ACK;
            end else if (cnt_r < len_r) begin
               state_nxt = CHECK;
            end else begin
               state_nxt = END;
            end
         end
         END: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Frame length, words done, burst size and the per-burst counters.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         len_r   <= {ADDR_BITS{1'b0}};
         cnt_r   <= {ADDR_BITS{1'b0}};
         blen_r  <= {BURST_BITS{1'b0}};
         bleft_r <= {BURST_BITS{1'b0}};
         dly_r   <= {DLY_BITS{1'b0}};
      end else begin
         if (state_r == ACK) begin
            len_r <= len_sync2_r;
            cnt_r <= {ADDR_BITS{1'b0}};
         end else if (drain_done_s) begin
            cnt_r <= cnt_r + ADDR_BITS'(blen_r);
         end
         if (start_s) begin
            blen_r  <= blen_s;
            bleft_r <= blen_s - BURST_BITS'(1);
         end else if (cmd_s) begin
            bleft_r <= bleft_r - BURST_BITS'(1);
         end
         if (state_r == ISSUE) begin
            dly_r <= DLY_BITS'(RD_LATENCY - 1);
         end else if (state_r == DRAIN) begin
            dly_r <= dly_r - DLY_BITS'(1);
         end
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         app_rd_en    <= ZERO;
         app_rd_addr  <= {ADDR_BITS{1'b0}};
         rd_busy      <= ZERO;
         read_req_ack <= ZERO;
         read_finish  <= ZERO;
         fifo_aclr    <= ZERO;
      end else begin
         app_rd_en <= cmd_s;
         if (cmd_s) begin
            app_rd_addr <= gen_addr_s;
         end
         rd_busy      <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
         read_req_ack <= (state_nxt == ACK);
         fifo_aclr    <= (state_nxt == ACK);
         read_finish  <= (state_nxt == END);
      end
   end

endmodule
